inst_loader: RTL
================

# inst_loader

Boot-time writer for the instruction memory that the fetch path reads through `pc[9:2]`. Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses of the instruction RAM's write port. Holds the CPU in reset until a load completes with a correct checksum, then releases it.

## Interface
- `ADDR_W`, 8, word-address width; matches the 256-word instruction RAM.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE, DONE, ERROR.
- `num_words`  in  ADDR_W+1  words to load; sampled on accepted `start`.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction RAM write enable.
- `mem_addr`  out  ADDR_W  word address.
- `mem_din`  out  32  word to write.
- `cpu_reset`  out  1  reset to PC/CPU; 1 = hold.
- `busy`  out  1  load in progress (RECV, WRITE, CHECK).
- `done`  out  1  last load succeeded.
- `error`  out  1  last load failed checksum.

## Operation
- States: IDLE, RECV, WRITE, CHECK, DONE, ERROR.
- Byte transfer occurs on a cycle with `in_valid && in_ready`. `in_ready` is a function of state only: 1 in RECV and CHECK, else 0.
- IDLE/DONE/ERROR + `start`: latch `num_words`, clamping values > 2^ADDR_W to 2^ADDR_W. Clear word index, byte count, running sum, `done`, `error`; set `cpu_reset`=1. Go to RECV, or to CHECK if the clamped count is 0.
- `start` in RECV/WRITE/CHECK is ignored.
- RECV: each transfer shifts the byte into the word register (first byte → bits 31:24, fourth → 7:0) and adds it to the 8-bit running sum (mod 256). The fourth transfer goes to WRITE.
- WRITE, exactly one cycle: `mem_we`=1, `mem_addr`=word index, `mem_din`=assembled word. Word index increments. If the new index equals the count, go to CHECK; else return to RECV with byte count 0.
- CHECK: one transfer. The byte is the checksum; it is not added to the sum.
  - Equal to the running sum: go to DONE with `done`=1 and `cpu_reset`=0.
  - Not equal: go to ERROR with `error`=1 and `cpu_reset`=1.
- DONE/ERROR hold until `start` or `reset`.
- No address wrap: the maximum count of 2^ADDR_W ends at address 2^ADDR_W-1.
- `mem_we` is 0 in every state other than WRITE.

## Timing
- Reset values: state IDLE, `cpu_reset`=1, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `busy`=0, `done`=0, `error`=0.
- `start` at cycle t: `busy`=1 and `in_ready`=1 at t+1.
- A word's write occurs the cycle after its fourth byte is accepted.
- Minimum 5 cycles per word (4 transfers + 1 write). `in_ready`=0 during WRITE.
- `done`/`error`, `busy`=0, and the `cpu_reset` change all appear the cycle after the checksum byte is accepted.
- Reset mid-load: all state returns to reset values on the next edge. Words already written remain in RAM; a partial word is discarded. A subsequent load restarts at address 0.
- `in_valid` may drop at any time; bytes are neither lost nor duplicated.

## Test plan
- Reset for 2 cycles → `cpu_reset`=1; `in_ready`, `mem_we`, `busy`, `done`, `error` all 0.
- `num_words`=2; bytes 20 08 00 05 8C 09 00 04, checksum C6 → write addr0=0x20080005 and addr1=0x8C090004, one `mem_we` pulse each. Then `done`=1, `cpu_reset`=0, `busy`=0.
- Same stream with checksum C7 → both words written; `error`=1, `done`=0, `cpu_reset` stays 1.
- Same stream, `in_valid` high every third cycle, plus a `start` pulse mid-RECV → identical writes and `done`. The extra `start` has no effect.
- `num_words`=0, checksum 00 → CHECK immediately, no `mem_we`, `done`=1. Checksum 01 → `error`=1.
- `reset` after 6 bytes accepted → addr0 write already done, IDLE next cycle, `cpu_reset`=1. New load of 1 word 24 0A 00 07, checksum 35 → addr0=0x240A0007, `done`=1.

Source files
------------

// File: rtl/inst_loader.sv
// Boot-time instruction RAM loader: assembles big-endian words from a byte stream,
// writes them to consecutive addresses and releases the CPU only on a good checksum.
module inst_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   word_idx_r;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       shift_r;
  logic [7:0]        sum_r;

  logic              xfer_s;
  logic [ADDR_W:0]   clamped_s;
  logic [ADDR_W:0]   next_idx_s;
  logic [31:0]       word_s;

  assign xfer_s     = in_valid && in_ready;
  assign clamped_s  = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
  assign next_idx_s = word_idx_r + {{ADDR_W{1'b0}}, 1'b1};
  assign word_s     = {shift_r, in_data};

  // Load sequencer; in_ready and busy are updated on every transition so they track the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      count_r    <= {(ADDR_W+1){1'b0}};
      word_idx_r <= {(ADDR_W+1){1'b0}};
      byte_cnt_r <= 2'd0;
      shift_r    <= 24'd0;
      sum_r      <= 8'd0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_din    <= 32'd0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state_r)
        IDLE, DONE, ERROR: begin
          if (start) begin
            count_r    <= clamped_s;
            word_idx_r <= {(ADDR_W+1){1'b0}};
            byte_cnt_r <= 2'd0;
            sum_r      <= 8'd0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
            if (clamped_s == {(ADDR_W+1){1'b0}}) begin
              state_r <= CHECK;
            end else begin
              state_r <= RECV;
            end
          end
        end
        RECV: begin
          if (xfer_s) begin
            shift_r    <= word_s[23:0];
            sum_r      <= sum_r + in_data;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              state_r  <= WRITE;
              in_ready <= 1'b0;
              mem_we   <= 1'b1;
              mem_addr <= word_idx_r[ADDR_W-1:0];
              mem_din  <= word_s;
            end
          end
        end
        WRITE: begin
          word_idx_r <= next_idx_s;
          byte_cnt_r <= 2'd0;
          in_ready   <= 1'b1;
          if (next_idx_s == count_r) begin
            state_r <= CHECK;
          end else begin
            state_r <= RECV;
          end
        end
        CHECK: begin
          // The checksum byte itself is compared, never accumulated.
          if (xfer_s) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == sum_r) begin
              state_r   <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state_r   <= ERROR;
              error     <= 1'b1;
              cpu_reset <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule
